// File: rtl/calc_pkg.sv
// Shared calc types and BCD constants, used by the converter and the display driver.
package calc_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam int unsigned BCD_W      = 4;
   localparam int unsigned BCD_ADJ_TH = 5;
   localparam int unsigned BCD_ADJ    = 3;

endpackage

// File: rtl/calc_bin2bcd_if.sv
// Request/result bundle between the calc multiplier side and the BCD converter.
interface calc_bin2bcd_if #(
   parameter int unsigned DW     = 16,
   parameter int unsigned DIGITS = 5
);
   logic                  start;
   logic [DW-1:0]         din;
   logic                  busy;
   logic                  done;
   logic                  sign;
   logic [4*DIGITS-1:0]   bcd;
   logic [2:0]            ndig;

   modport master (output start, din, input busy, done, sign, bcd, ndig);
   modport slave  (input start, din, output busy, done, sign, bcd, ndig);
endinterface

// File: rtl/calc_bcd_adj3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added before the shift.
module calc_bcd_adj3
   import calc_pkg::*;
(
   input  logic [BCD_W-1:0] d,
   output logic [BCD_W-1:0] q_c
);

   always_comb begin
      q_c = d;
      if (d >= BCD_W'(BCD_ADJ_TH)) begin
         q_c = d + BCD_W'(BCD_ADJ);
      end
   end

endmodule

// File: rtl/calc_bin2bcd.sv
// Signed binary to BCD converter: sign flag, DIGITS BCD digits and a significant-digit
// count, one double-dabble shift per clock.
module calc_bin2bcd
   import calc_pkg::*;
#(
   parameter int unsigned DW     = 16,
   parameter int unsigned DIGITS = 5
) (
   input  logic           sys_clk,
   input  logic           sys_rst_n,
   calc_bin2bcd_if.slave  bus
);

   localparam int unsigned ACC_W = BCD_W * DIGITS;
   localparam int unsigned CNT_W = $clog2(DW);

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [DW-1:0]      mag, mag_n;
   logic [ACC_W-1:0]   acc, acc_n;
   logic               sign_r, sign_r_n;

   logic               busy_q, busy_n;
   logic               done_q, done_n;
   logic               sign_q, sign_n;
   logic [ACC_W-1:0]   bcd_q, bcd_n;
   logic [2:0]         ndig_q, ndig_n;

   logic [ACC_W-1:0]      adj_c;
   logic [ACC_W+DW-1:0]   sh_c;
   logic [2:0]            ndig_c;
   logic [DW-1:0]         abs_c;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      calc_bcd_adj3 u_adj (
         .d   (acc[i*BCD_W +: BCD_W]),
         .q_c (adj_c[i*BCD_W +: BCD_W])
      );
   end

   // Corrected accumulator and magnitude shift as one long register.
   always_comb begin
      sh_c = {adj_c, mag} << 1;
   end

   // Most significant non-zero digit of the shifted accumulator; zero still shows one digit.
   always_comb begin
      ndig_c = 3'd1;
      for (int i = 0; i < DIGITS; i++) begin
         if (sh_c[DW + i*BCD_W +: BCD_W] != '0) begin
            ndig_c = 3'(i + 1);
         end
      end
   end

   // Two's-complement magnitude; the most negative input maps onto its unsigned pattern.
   always_comb begin
      abs_c = bus.din;
      if (bus.din[DW-1]) begin
         abs_c = DW'(~bus.din + DW'(1));
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      mag_n    = mag;
      acc_n    = acc;
      sign_r_n = sign_r;
      busy_n   = busy_q;
      done_n   = 1'b0;
      sign_n   = sign_q;
      bcd_n    = bcd_q;
      ndig_n   = ndig_q;

      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_n  = ST_SHIFT;
               sign_r_n = bus.din[DW-1];
               mag_n    = abs_c;
               acc_n    = '0;
               cnt_n    = '0;
               busy_n   = 1'b1;
            end
         end
         ST_SHIFT: begin
            acc_n = sh_c[ACC_W+DW-1:DW];
            mag_n = sh_c[DW-1:0];
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DW - 1)) begin
               state_n = ST_IDLE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               sign_n  = sign_r;
               bcd_n   = sh_c[ACC_W+DW-1:DW];
               ndig_n  = ndig_c;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         mag    <= '0;
         acc    <= '0;
         sign_r <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         sign_q <= 1'b0;
         bcd_q  <= '0;
         ndig_q <= 3'd1;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         mag    <= mag_n;
         acc    <= acc_n;
         sign_r <= sign_r_n;
         busy_q <= busy_n;
         done_q <= done_n;
         sign_q <= sign_n;
         bcd_q  <= bcd_n;
         ndig_q <= ndig_n;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sign = sign_q;
   assign bus.bcd  = bcd_q;
   assign bus.ndig = ndig_q;

endmodule

// File: tb/tb_calc_bin2bcd.sv
// Bench for calc_bin2bcd: arithmetic reference model checked every cycle, plus
// directed conversions with hand-computed results, latency and busy-length checks.
module tb_calc_bin2bcd;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;

   calc_bin2bcd_if #(.DW(16), .DIGITS(5)) bus ();

   calc_bin2bcd #(.DW(16), .DIGITS(5)) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: decimal digits by repeated division.
   function automatic logic [19:0] ref_bcd(input logic [15:0] d);
      int m;
      logic [19:0] r;
      m = int'($signed(d));
      if (m < 0) m = -m;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   function automatic logic [2:0] ref_ndig(input logic [15:0] d);
      int m;
      int n;
      m = int'($signed(d));
      if (m < 0) m = -m;
      n = 1;
      while (m >= 10) begin
         m = m / 10;
         n++;
      end
      return 3'(n);
   endfunction

   function automatic logic ref_sign(input logic [15:0] d);
      return (int'($signed(d)) < 0);
   endfunction

   // Transaction-level model: accept when idle, result appears 16 edges later.
   logic        m_busy = 1'b0, m_done = 1'b0, m_sign = 1'b0;
   logic [19:0] m_bcd = '0, p_bcd = '0;
   logic [2:0]  m_ndig = 3'd1, p_ndig = 3'd1;
   logic        p_sign = 1'b0;
   int          rem = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_done = 1'b0; m_sign = 1'b0; m_bcd = '0; m_ndig = 3'd1; rem = 0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            rem--;
            if (rem == 0) begin
               m_busy = 1'b0; m_done = 1'b1;
               m_sign = p_sign; m_bcd = p_bcd; m_ndig = p_ndig;
            end
         end else if (bus.start) begin
            m_busy = 1'b1; rem = 16;
            p_sign = ref_sign(bus.din); p_bcd = ref_bcd(bus.din); p_ndig = ref_ndig(bus.din);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_busy", 32'(bus.busy), 32'(m_busy));
         chk("model_done", 32'(bus.done), 32'(m_done));
         chk("model_sign", 32'(bus.sign), 32'(m_sign));
         chk("model_bcd",  32'(bus.bcd),  32'(m_bcd));
         chk("model_ndig", 32'(bus.ndig), 32'(m_ndig));
      end
   end

   // One isolated conversion; done is expected on the 17th falling edge after start is driven.
   task automatic run(input string name, input logic [15:0] d, input logic [19:0] eb,
                      input logic es, input logic [2:0] en);
      int n;
      int nb;
      bit got;
      @(negedge clk);
      bus.din = d; bus.start = 1'b1;
      n = 0; nb = 0; got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         bus.start = 1'b0;
         n++;
         if (bus.busy) nb++;
         if (bus.done) got = 1'b1;
      end
      chk({name, "_done_seen"}, 32'(got), 32'd1);
      chk({name, "_latency"}, 32'(n), 32'd17);
      chk({name, "_busy_cycles"}, 32'(nb), 32'd16);
      chk({name, "_bcd"}, 32'(bus.bcd), 32'(eb));
      chk({name, "_sign"}, 32'(bus.sign), 32'(es));
      chk({name, "_ndig"}, 32'(bus.ndig), 32'(en));
   endtask

   initial begin
      int last;
      int nd;
      bit saw_done;
      bus.start = 1'b0;
      bus.din = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_sign", 32'(bus.sign), 32'd0);
      chk("rst_bcd",  32'(bus.bcd),  32'd0);
      chk("rst_ndig", 32'(bus.ndig), 32'd1);
      rst_n = 1'b1;
      chk_en = 1'b1;

      run("zero",  16'h0000, 20'h00000, 1'b0, 3'd1);
      run("p12345", 16'h3039, 20'h12345, 1'b0, 3'd5);
      run("m10",   16'hFFF6, 20'h00010, 1'b1, 3'd2);
      run("p32767", 16'h7FFF, 20'h32767, 1'b0, 3'd5);
      run("m32768", 16'h8000, 20'h32768, 1'b1, 3'd5);
      run("p9",    16'h0009, 20'h00009, 1'b0, 3'd1);
      run("m1",    16'hFFFF, 20'h00001, 1'b1, 3'd1);

      // start held high: back-to-back results, din glitch mid-conversion ignored
      @(negedge clk);
      bus.din = 16'h0064; bus.start = 1'b1;
      last = -1; nd = 0;
      for (int n = 1; n <= 80; n++) begin
         @(negedge clk);
         if (n == 25) bus.din = 16'h0001;
         if (n == 26) bus.din = 16'h0064;
         if (bus.done) begin
            nd++;
            chk("b2b_bcd", 32'(bus.bcd), 32'h00100);
            chk("b2b_ndig", 32'(bus.ndig), 32'd3);
            if (last >= 0) chk("b2b_period", 32'(n - last), 32'd17);
            last = n;
            if (nd == 3) begin
               bus.start = 1'b0;
               break;
            end
         end
      end
      chk("b2b_count", 32'(nd), 32'd3);

      // reset in the middle of a conversion
      @(negedge clk);
      bus.din = 16'h3039; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_bcd",  32'(bus.bcd),  32'd0);
      chk("abort_ndig", 32'(bus.ndig), 32'd1);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) saw_done = 1'b1;
      end
      chk("abort_no_done", 32'(saw_done), 32'd0);
      run("p5", 16'h0005, 20'h00005, 1'b0, 3'd1);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
